// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
//
// Purpose: bundles the fetch stage's bus-facing signals into one interface.
//          It carries the instruction-memory request/grant/response channel,
//          the branch redirect from execute, and the valid/ready channel
//          towards decode.
//
// Modports:
//   master - the fetch stage itself (drives the memory request and the decode
//            outputs; samples grant, response, redirect and decode ready)
//   slave  - the environment (memory, execute and decode side)
//
// Signals:
//   imem_req_o     1   memory read request valid
//   imem_addr_o    32  word-aligned byte address of the request
//   imem_gnt_i     1   request accepted this cycle
//   imem_rvalid_i  1   read data valid (in-order responses)
//   imem_rdata_i   32  read data
//   redirect_i     1   taken branch from execute
//   redirect_pc_i  32  branch target (bits [1:0] ignored)
//   instr_valid_o  1   buffer head valid
//   instr_ready_i  1   decode accepts the head
//   instr_o        32  head instruction
//   instr_pc_o     32  head PC
//   op_o           7   head opcode field (instr_o[6:0])
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic [6:0]  op_o;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      input  redirect_i,
      input  redirect_pc_i,
      output instr_valid_o,
      input  instr_ready_i,
      output instr_o,
      output instr_pc_o,
      output op_o
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      output redirect_i,
      output redirect_pc_i,
      input  instr_valid_o,
      output instr_ready_i,
      input  instr_o,
      input  instr_pc_o,
      input  op_o
   );
endinterface

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Purpose: instruction fetch stage. It owns the program counter, issues one
//          word read at a time to instruction memory, and queues the returned
//          instructions in a small in-order buffer. Decode reads the head of
//          that buffer under a valid/ready handshake. A taken branch flushes
//          the buffer, discards any fetch still in flight, and restarts
//          fetching at the branch target.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   DEPTH     fetch buffer entries (power of two, >= 2)
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        asynchronous active-high reset
//   bus          if_fetch_stage_if.master (memory, redirect, decode channels)
//   fetch_cnt_o  (IF_PERF_CNT_EN only) number of instructions handed to decode
//   flush_cnt_o  (IF_PERF_CNT_EN only) number of redirect cycles seen
//
// Build option:
//   IF_PERF_CNT_EN  when defined, adds the two 32-bit performance counters.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   if_fetch_stage_if.master bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]      fetch_cnt_o,
   output logic [31:0]      flush_cnt_o
`endif
);

   localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W   = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic {
      IDLE,
      WAIT
   } fetch_state_t;

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      tag_pc_q;
   logic             started_q;
   logic             drop_q, drop_d;

   logic [31:0]      fifo_pc_q    [DEPTH];
   logic [31:0]      fifo_instr_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic             head_valid;
   logic             grant;
   logic             resp;
   logic             push;
   logic             pop;
   logic             unused_redirect_lsbs;

   // The request depends only on registered state: fetching has started, no
   // request is outstanding and there is guaranteed room for its response.
   // Reserving the slot up front is what makes a push into a full buffer
   // impossible.
   assign head_valid       = (count_q != '0);
   assign bus.imem_req_o   = started_q && (state_q == IDLE) && (count_q < DEPTH_C);
   assign bus.imem_addr_o  = pc_q;
   assign grant            = bus.imem_req_o && bus.imem_gnt_i;
   assign resp             = (state_q == WAIT) && bus.imem_rvalid_i;
   assign push             = resp && !drop_q && !bus.redirect_i;
   assign pop              = head_valid && bus.instr_ready_i && !bus.redirect_i;

   // Decode sees the registered head entry directly, so the outputs cannot
   // change while decode is stalling.
   assign bus.instr_valid_o = head_valid;
   assign bus.instr_o       = fifo_instr_q[rd_ptr_q];
   assign bus.instr_pc_o    = fifo_pc_q[rd_ptr_q];
   assign bus.op_o          = fifo_instr_q[rd_ptr_q][6:0];

   assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];

   // Next-state logic for the request FSM, the PC and the drop flag.
   // A grant advances the PC and moves to WAIT; a response returns to IDLE.
   // A redirect overrides the PC. If a fetch is still in flight after this
   // edge (fresh grant, or WAIT without a response yet), drop is set so its
   // response is thrown away when it arrives. A response landing in the
   // redirect cycle is discarded directly, so drop ends up clear.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;

      if (grant) begin
         state_d = WAIT;
         pc_d    = pc_q + 32'd4;
      end else if (resp) begin
         state_d = IDLE;
      end

      if (resp && drop_q) begin
         drop_d = 1'b0;
      end

      if (bus.redirect_i) begin
         pc_d = {bus.redirect_pc_i[31:2], 2'b00};
         if (grant) begin
            drop_d = 1'b1;
         end else if ((state_q == WAIT) && !bus.imem_rvalid_i) begin
            drop_d = 1'b1;
         end else begin
            drop_d = 1'b0;
         end
      end
   end

   // Control state registers. started holds off the first request until one
   // full cycle after reset is released. The granted address is kept as the
   // tag for the response, because pc has already moved on by then.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         tag_pc_q  <= '0;
         started_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         started_q <= 1'b1;
         if (grant) begin
            tag_pc_q <= pc_q;
         end
      end
   end

   // In-order fetch buffer. A redirect empties it by resetting the pointers,
   // and that takes precedence over any push or pop in the same cycle. The
   // storage is cleared on reset so the decode outputs read zero while empty.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (bus.redirect_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_pc_q[wr_ptr_q]    <= tag_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata_i;
            wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

`ifdef IF_PERF_CNT_EN
   // Free-running performance counters that wrap naturally at 2^32. Only real
   // handoffs to decode are counted; a pop cancelled by a redirect is not.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (pop) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
         end
         if (bus.redirect_i) begin
            flush_cnt_o <= flush_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. An instruction memory model answers requests with
// random grant timing and latency. It also injects stray rvalid pulses while
// nothing is outstanding. The expected decode stream is the program-order
// sequence of words starting at the current PC; it restarts at the target on
// every redirect and at RESET_PC on every reset. A monitor compares each head
// presented to decode against the front of that stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic clk_i = 1'b0;
   logic rst_i;

   if_fetch_stage_if bus ();

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   if_fetch_stage #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o (fetch_cnt_o),
      .flush_cnt_o (flush_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks    = 0;
   int failures  = 0;
   int cycle     = 0;
   int pops_seen = 0;
   int flushes   = 0;

   always @(posedge clk_i) cycle <= cycle + 1;

   // ---------------- memory contents and expected program stream ------------
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      if (!mem.exists(addr)) mem[addr] = $urandom;
      return mem[addr];
   endfunction

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      exp_q[$];
   logic [31:0] cursor;

   task automatic topUp();
      while (exp_q.size() < 32) begin
         exp_q.push_back({cursor, memWord(cursor)});
         cursor = cursor + 32'd4;
      end
   endtask

   task automatic restartProgram(input logic [31:0] target);
      exp_q.delete();
      cursor = {target[31:2], 2'b00};
      topUp();
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // ---------------- instruction memory model ------------------------------
   typedef struct {
      logic [31:0] addr;
      int          cyc;
   } grant_t;

   grant_t grant_log[$];
   int     gnt_pct   = 100;
   int     lat_min   = 1;
   int     lat_max   = 1;
   int     stray_pct = 0;
   bit     outstanding = 1'b0;
   int     wait_cnt  = 0;
   logic [31:0] out_addr;

   function automatic logic [31:0] logAddr(input int i);
      if (i < grant_log.size()) return grant_log[i].addr;
      return 32'hDEAD_BEEF;
   endfunction

   // Handshakes are sampled at the negative edge and acted on just after the
   // following rising edge, when the memory drives the next cycle's signals.
   initial begin : memory_model
      bit          fire;
      bit          resp_now;
      logic [31:0] fire_addr;
      bus.imem_gnt_i    = 1'b0;
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = '0;
      resp_now          = 1'b0;
      forever begin
         @(negedge clk_i);
         fire      = bus.imem_req_o && bus.imem_gnt_i && !rst_i;
         fire_addr = bus.imem_addr_o;
         @(posedge clk_i);
         #1;
         if (resp_now) outstanding = 1'b0;
         if (fire) begin
            outstanding = 1'b1;
            out_addr    = fire_addr;
            wait_cnt    = int'($urandom_range(lat_max, lat_min)) - 1;
            grant_log.push_back('{fire_addr, cycle});
         end
         resp_now = 1'b0;
         if (outstanding) begin
            if (wait_cnt == 0) begin
               bus.imem_rvalid_i = 1'b1;
               bus.imem_rdata_i  = memWord(out_addr);
               resp_now          = 1'b1;
            end else begin
               wait_cnt--;
               bus.imem_rvalid_i = 1'b0;
            end
         end else if (int'($urandom_range(99)) < stray_pct) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = $urandom;
         end else begin
            bus.imem_rvalid_i = 1'b0;
         end
         bus.imem_gnt_i = !outstanding && (int'($urandom_range(99)) < gnt_pct);
      end
   end

   // ---------------- decode-side monitor / scoreboard ----------------------
   initial begin : monitor
      entry_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && !bus.redirect_i && bus.instr_valid_o) begin
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               checkOutput("head_pc", bus.instr_pc_o, e.pc);
               checkOutput("head_instr", bus.instr_o, e.instr);
               checkOutput("head_op", 32'(bus.op_o), 32'(e.instr[6:0]));
               if (bus.instr_ready_i) begin
                  void'(exp_q.pop_front());
                  pops_seen++;
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic tick();
      @(posedge clk_i);
      #2;
      topUp();
   endtask

   task automatic waitGrantCount(input int n, input int budget, input string name);
      int k = 0;
      while (grant_log.size() < n && k < budget) begin
         tick();
         k++;
      end
      checkOutput(name, 32'(grant_log.size() >= n), 32'd1);
   endtask

   task automatic doRedirect(input logic [31:0] target);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = target;
      restartProgram(target);
      flushes++;
      tick();
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = $urandom;
   endtask

   task automatic pulseReset();
      rst_i        = 1'b1;
      bus.redirect_i = 1'b0;
      restartProgram(RESET_PC);
      grant_log.delete();
      pops_seen = 0;
      flushes   = 0;
      @(negedge clk_i);
      checkOutput("rst_req", 32'(bus.imem_req_o), 32'd0);
      checkOutput("rst_addr", bus.imem_addr_o, RESET_PC);
      checkOutput("rst_valid", 32'(bus.instr_valid_o), 32'd0);
      checkOutput("rst_instr", bus.instr_o, 32'd0);
      checkOutput("rst_pc", bus.instr_pc_o, 32'd0);
      checkOutput("rst_op", 32'(bus.op_o), 32'd0);
`ifdef IF_PERF_CNT_EN
      checkOutput("rst_fetch_cnt", fetch_cnt_o, 32'd0);
      checkOutput("rst_flush_cnt", flush_cnt_o, 32'd0);
`endif
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("req_before_start", 32'(bus.imem_req_o), 32'd0);
      tick();
      checkOutput("req_after_start", 32'(bus.imem_req_o), 32'd1);
      checkOutput("addr_after_start", bus.imem_addr_o, RESET_PC);
   endtask

   task automatic applyStimulus(input int n);
      logic [31:0] t;
      gnt_pct   = 60;
      lat_min   = 1;
      lat_max   = 3;
      stray_pct = 10;
      for (int i = 0; i < n; i++) begin
         bus.instr_ready_i = (int'($urandom_range(99)) < 70);
         if (int'($urandom_range(99)) < 3) begin
            case ($urandom_range(2))
               0:       t = 32'($urandom_range(255));
               1:       t = 32'hFFFF_FFE0 + 32'($urandom_range(31));
               default: t = $urandom;
            endcase
            doRedirect(t);
         end else begin
            tick();
         end
      end
   endtask

   // ---------------- main sequence -----------------------------------------
   initial begin : stimulus
      int k;
      logic [31:0] a;
      rst_i             = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      bus.instr_ready_i = 1'b0;
      restartProgram(RESET_PC);

      // Decode stalled: exactly two fetches fill the buffer, then requests stop.
      pulseReset();
      for (int i = 0; i < 12; i++) tick();
      checkOutput("stall_grants", 32'(grant_log.size()), 32'd2);
      checkOutput("stall_addr0", logAddr(0), 32'h0);
      checkOutput("stall_addr1", logAddr(1), 32'h4);
      checkOutput("stall_req_low", 32'(bus.imem_req_o), 32'd0);
      checkOutput("stall_valid", 32'(bus.instr_valid_o), 32'd1);
      checkOutput("stall_head_pc", bus.instr_pc_o, RESET_PC);

      // Release decode: drain, resume at 0x8, then one grant every two cycles.
      bus.instr_ready_i = 1'b1;
      waitGrantCount(5, 40, "resume_grants");
      checkOutput("resume_addr2", logAddr(2), 32'h8);
      checkOutput("resume_addr3", logAddr(3), 32'hC);
      checkOutput("resume_addr4", logAddr(4), 32'h10);
      if (grant_log.size() >= 5)
         checkOutput("grant_spacing", 32'(grant_log[4].cyc - grant_log[3].cyc), 32'd2);

      // Redirect while a fetch is outstanding and its response not yet back.
      lat_min = 3;
      lat_max = 3;
      k = 0;
      while (!(outstanding && !bus.imem_rvalid_i) && k < 40) begin tick(); k++; end
      checkOutput("found_outstanding", 32'(outstanding && !bus.imem_rvalid_i), 32'd1);
      grant_log.delete();
      doRedirect(32'h0000_0100);
      waitGrantCount(1, 40, "redir_wait_grant");
      checkOutput("redir_addr", logAddr(0), 32'h100);

      // Redirect in the same cycle as a grant: that fetch is dropped.
      lat_min = 1;
      lat_max = 2;
      k = 0;
      while (!(bus.imem_req_o && bus.imem_gnt_i) && k < 40) begin tick(); k++; end
      checkOutput("found_grant", 32'(bus.imem_req_o && bus.imem_gnt_i), 32'd1);
      a = bus.imem_addr_o;
      grant_log.delete();
      doRedirect(32'h0000_0203);
      waitGrantCount(2, 40, "redir_gnt_wait");
      checkOutput("redir_gnt_addr0", logAddr(0), a);
      checkOutput("redir_gnt_addr1", logAddr(1), 32'h200);

      // PC wrap from the top of the address space.
      k = 0;
      while (bus.imem_req_o && k < 40) begin tick(); k++; end
      grant_log.delete();
      doRedirect(32'hFFFF_FFFC);
      waitGrantCount(2, 40, "wrap_wait");
      checkOutput("wrap_addr0", logAddr(0), 32'hFFFF_FFFC);
      checkOutput("wrap_addr1", logAddr(1), 32'h0000_0000);

      // Reset in the middle of a slow fetch; its late response must be ignored.
      lat_min = 6;
      lat_max = 6;
      k = 0;
      while (!(outstanding && wait_cnt >= 3) && k < 60) begin tick(); k++; end
      checkOutput("found_slow_fetch", 32'(outstanding && wait_cnt >= 3), 32'd1);
      pulseReset();
      lat_min = 1;
      lat_max = 1;
      k = 0;
      while (outstanding && k < 40) begin tick(); k++; end
      checkOutput("stale_consumed", 32'(outstanding), 32'd0);
      checkOutput("stale_no_push", 32'(bus.instr_valid_o), 32'd0);
      waitGrantCount(1, 40, "restart_wait");
      checkOutput("restart_addr", logAddr(0), RESET_PC);

      // Randomised traffic, then drain with decode always ready.
      applyStimulus(3000);
      gnt_pct           = 100;
      stray_pct         = 0;
      bus.instr_ready_i = 1'b1;
      for (int i = 0; i < 20; i++) tick();
`ifdef IF_PERF_CNT_EN
      checkOutput("fetch_cnt", fetch_cnt_o, 32'(pops_seen));
      checkOutput("flush_cnt", flush_cnt_o, 32'(flushes));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule
